// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, alu_op, state and select encodings for the multicycle MIPS control path
package mips_pkg;
  localparam int OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_J = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_LW = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW = 6'd43;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFORMAT = 2'b10;
  localparam logic [1:0] ALUOP_AND = 2'b11;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IMM_EX = 4'd9,
    S_IMM_WB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/mem_ready inputs and datapath control outputs of the main FSM
interface multicycle_control_if;
  import mips_pkg::*;
  logic [OPCODE_W-1:0] opcode;
  logic mem_ready;
  logic pc_write;
  logic pc_write_cond;
  logic i_or_d;
  logic mem_read;
  logic mem_write;
  logic ir_write;
  logic mem_to_reg;
  logic reg_dst;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  modport master (
    input opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state
  );
  modport slave (
    output opcode, mem_ready,
    input pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    input mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing multicycle MIPS instructions and decoding datapath controls
module multicycle_control
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master m
);
  state_e state_q, state_d;
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = S_FETCH;
    m.pc_write = 1'b0;
    m.pc_write_cond = 1'b0;
    m.i_or_d = 1'b0;
    m.mem_read = 1'b0;
    m.mem_write = 1'b0;
    m.ir_write = 1'b0;
    m.mem_to_reg = 1'b0;
    m.reg_dst = 1'b0;
    m.reg_write = 1'b0;
    m.alu_src_a = 1'b0;
    m.alu_src_b = SRCB_B;
    m.alu_op = ALUOP_ADD;
    m.pc_source = PCSRC_ALU;
    m.state = state_q;
    case (state_q)
      S_FETCH: begin
        m.mem_read = 1'b1;
        m.alu_src_b = SRCB_FOUR;
        m.ir_write = m.mem_ready;
        m.pc_write = m.mem_ready;
        state_d = m.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        m.alu_src_b = SRCB_IMM_SH2;
        state_d = (m.opcode == OP_RTYPE) ? S_EXEC :
                  (m.opcode == OP_LW || m.opcode == OP_SW) ? S_MEMADR :
                  (m.opcode == OP_BEQ) ? S_BRANCH :
                  (m.opcode == OP_ADDI || m.opcode == OP_ANDI) ? S_IMM_EX :
                  (m.opcode == OP_J) ? S_JUMP : S_FETCH;
      end
      S_MEMADR: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = SRCB_IMM;
        state_d = (m.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        m.mem_read = 1'b1;
        m.i_or_d = 1'b1;
        state_d = m.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        m.reg_write = 1'b1;
        m.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        m.mem_write = 1'b1;
        m.i_or_d = 1'b1;
        state_d = m.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        m.alu_src_a = 1'b1;
        m.alu_op = ALUOP_RFORMAT;
        state_d = S_RWB;
      end
      S_RWB: begin
        m.reg_write = 1'b1;
        m.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        m.alu_src_a = 1'b1;
        m.alu_op = ALUOP_SUB;
        m.pc_write_cond = 1'b1;
        m.pc_source = PCSRC_ALUOUT;
      end
      S_IMM_EX: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = SRCB_IMM;
        m.alu_op = (m.opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
        state_d = S_IMM_WB;
      end
      S_IMM_WB: m.reg_write = 1'b1;
      S_JUMP: begin
        m.pc_write = 1'b1;
        m.pc_source = PCSRC_JUMP;
      end
      default: state_d = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector self-checking bench for the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] strobes();
    return {bus.pc_write, bus.pc_write_cond, bus.mem_write, bus.reg_write, bus.ir_write};
  endfunction
  initial begin
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    step();
    step();
    check("rst_state", bus.state, 0);
    check("rst_mem_read", bus.mem_read, 1);
    check("rst_srcb", bus.alu_src_b, 2'b01);
    check("rst_pc_write", bus.pc_write, 1);
    check("rst_ir_write", bus.ir_write, 1);
    check("rst_reg_write", bus.reg_write, 0);
    check("rst_mem_write", bus.mem_write, 0);
    reset = 1'b0;
    // lw: 0,1,2,3,4,0
    bus.opcode = 6'd35;
    step(); check("lw_s1", bus.state, 1); check("dec_srcb", bus.alu_src_b, 2'b11);
    step(); check("lw_s2", bus.state, 2); check("adr_srca", bus.alu_src_a, 1); check("adr_srcb", bus.alu_src_b, 2'b10);
    step(); check("lw_s3", bus.state, 3); check("rd_mem_read", bus.mem_read, 1); check("rd_iord", bus.i_or_d, 1);
    step(); check("lw_s4", bus.state, 4); check("wb_reg_write", bus.reg_write, 1); check("wb_m2r", bus.mem_to_reg, 1); check("wb_regdst", bus.reg_dst, 0);
    step(); check("lw_s0", bus.state, 0);
    // sw with three low mem_ready cycles in MEMWR
    bus.opcode = 6'd43;
    step(); check("sw_s1", bus.state, 1);
    step(); check("sw_s2", bus.state, 2);
    step(); check("sw_s5", bus.state, 5);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      check("sw_hold", bus.state, 5);
      check("sw_mem_write", bus.mem_write, 1);
      check("sw_iord", bus.i_or_d, 1);
      check("sw_no_regw", bus.reg_write, 0);
      step();
    end
    check("sw_s0", bus.state, 0);
    // FETCH stall
    bus.mem_ready = 1'b0;
    #1 check("fetch_stall_ir", bus.ir_write, 0);
    check("fetch_stall_pc", bus.pc_write, 0);
    step(); check("fetch_hold", bus.state, 0);
    bus.mem_ready = 1'b1;
    // R-type
    bus.opcode = 6'd0;
    step(); check("r_s1", bus.state, 1);
    step(); check("r_s6", bus.state, 6); check("exec_aluop", bus.alu_op, 2'b10); check("exec_srcb", bus.alu_src_b, 2'b00); check("exec_srca", bus.alu_src_a, 1);
    step(); check("r_s7", bus.state, 7); check("rwb_regdst", bus.reg_dst, 1); check("rwb_regw", bus.reg_write, 1);
    step(); check("r_s0", bus.state, 0);
    // andi
    bus.opcode = 6'd12;
    step(); check("andi_s1", bus.state, 1);
    step(); check("andi_s9", bus.state, 9); check("andi_aluop", bus.alu_op, 2'b11); check("andi_srcb", bus.alu_src_b, 2'b10);
    step(); check("andi_s10", bus.state, 10); check("immwb_regdst", bus.reg_dst, 0); check("immwb_regw", bus.reg_write, 1);
    step(); check("andi_s0", bus.state, 0);
    // addi
    bus.opcode = 6'd8;
    step(); step(); check("addi_s9", bus.state, 9); check("addi_aluop", bus.alu_op, 2'b00);
    step(); check("addi_s10", bus.state, 10);
    step(); check("addi_s0", bus.state, 0);
    // beq
    bus.opcode = 6'd4;
    step(); check("beq_s1", bus.state, 1);
    step(); check("beq_s8", bus.state, 8); check("br_pwc", bus.pc_write_cond, 1); check("br_aluop", bus.alu_op, 2'b01); check("br_pcsrc", bus.pc_source, 2'b01); check("br_pcw", bus.pc_write, 0);
    step(); check("beq_s0", bus.state, 0);
    // j
    bus.opcode = 6'd2;
    step(); check("j_s1", bus.state, 1);
    step(); check("j_s11", bus.state, 11); check("j_pcw", bus.pc_write, 1); check("j_pcsrc", bus.pc_source, 2'b10); check("j_pwc", bus.pc_write_cond, 0);
    step(); check("j_s0", bus.state, 0);
    // illegal opcode
    bus.opcode = 6'd63;
    step(); check("ill_s1", bus.state, 1); check("ill_strobes", strobes(), 0);
    step(); check("ill_s0", bus.state, 0);
    // reset during MEMRD wait
    bus.opcode = 6'd35;
    step(); step(); step(); check("rstrd_s3", bus.state, 3);
    bus.mem_ready = 1'b0;
    step(); check("rstrd_hold", bus.state, 3);
    reset = 1'b1;
    step(); check("rstrd_s0", bus.state, 0); check("rstrd_ir", bus.ir_write, 0);
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
